multi_trig_gen: RTL
===================

// Module: multi_trig_gen
// PURPOSE
//  Parametrised multi-channel trigger generator; successor to the single-channel CMOS trigger block.
//  A shared prescaler produces a base tick. NCH independent channels each drive a periodic or one-shot
//  pulse with programmable period, width and start delay, all counted in ticks.
//  Sits between the AXI-lite register bank (config inputs) and the camera/strobe trigger pins.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  clk frequency in Hz
//  TICK_HZ      1_000        base tick rate; DIV = CLK_FREQ_HZ/TICK_HZ, must be integer and >= 2
//  NCH          4            number of trigger channels, 1..16
//  CNT_W        16           width of the period, width and delay fields, in ticks
// PORTS
//  clk             in   1          system clock
//  rst_n           in   1          synchronous reset, active low
//  trig_en         in   NCH        per-channel enable
//  trig_mode       in   NCH        0 = continuous, 1 = one-shot
//  trig_fire       in   NCH        one-shot arm strobe, 1 clk, per channel
//  trig_period     in   NCH*CNT_W  period in ticks; ch i is at [i*CNT_W +: CNT_W]
//  trig_width      in   NCH*CNT_W  high time in ticks
//  trig_delay      in   NCH*CNT_W  start offset in ticks
//  tick_out        out  1          1-clk pulse at each base tick
//  trig_out        out  NCH        trigger outputs, registered
//  trig_busy       out  NCH        channel not in IDLE
// BEHAVIOUR
//  - Reset: prescaler=0, all channels IDLE, arm=0. tick_out, trig_out and trig_busy are all 0.
//  - Prescaler: counts 0..DIV-1 and wraps. tick is 1 when cnt==DIV-1. tick_out is registered, 1 clk wide.
//  - All channel state changes only on a tick cycle, except enable-drop and reset.
//  - Per-channel FSM is IDLE -> DELAY -> RUN.
//  - Counter dc (CNT_W bits) counts in DELAY; counter pc (CNT_W bits) counts in RUN.
//  - Shadow registers P, W and D latch period, width and delay on every IDLE exit and every period wrap.
//    Config changes mid-period take effect only at the next period boundary.
//  - IDLE exit condition:
//      continuous: tick & en & period!=0
//      one-shot:   tick & en & arm & period!=0
//  - arm is set by trig_fire while IDLE & en; it is cleared on IDLE exit.
//    trig_fire in any other state is ignored.
//  - On IDLE exit: go to DELAY with dc=0 if D!=0, else RUN with pc=0.
//  - DELAY: on tick, dc++. When dc==D-1 on a tick, go to RUN with pc=0.
//  - RUN: on tick, pc++. When pc==P-1 on a tick (period end):
//      continuous & en: reload P/W (D is not reapplied), pc=0, stay in RUN
//      one-shot: go to IDLE
//  - trig_out is 1 iff state==RUN and pc<W.
//      W=0: output never rises.
//      W>=P: output stays high for the whole period, continuously in continuous mode.
//  - Latency: the first rising edge of trig_out is registered 1 clk after the start tick when D=0.
//    Channels started on the same tick with equal P stay phase-locked, offset by their D.
//  - en=0 in any state: the next clk forces IDLE, trig_out=0, arm=0. This cuts a pulse short; no drain.
//  - P latched as 0 cannot occur, because the IDLE exit is gated on period!=0.
//  - trig_busy = (state!=IDLE).
//  - rst_n low mid-operation: all state returns to reset values on the next clk. No partial pulses are kept.
// CONFIGURATION
//  Macro TRIG_PULSE_CNT_EN.
//  - When defined: adds output trig_pulse_cnt  out  NCH*32, a per-channel count of trig_out rising edges.
//    Each count wraps at 2^32-1 -> 0, is cleared by rst_n and holds its value while en=0.
//  - When undefined: the port and counters are absent. All other behaviour is identical.
// TESTING
//  Bench config: CLK_FREQ_HZ=100_000, TICK_HZ=10_000 (DIV=10), NCH=4, CNT_W=16.
//  1. rst_n=0 for 5 clk with all en=1 -> tick_out, trig_out and trig_busy all 0.
//     After release, first tick_out on clk 10.
//  2. ch0 continuous P=5 W=2 D=0 -> trig_out high 20 clk, low 30 clk, repeating every 50 clk.
//     trig_busy stays 1.
//  3. ch1 same as ch0 with D=3, enabled in the same cycle -> each ch1 rising edge is 30 clk after ch0's.
//  4. ch0: W changed 2->4 mid-period -> current pulse stays 20 clk wide, next pulse is 40 clk.
//     W=5 -> constant high. W=0 -> constant low with busy=1.
//  5. ch2 one-shot P=6 W=4: one trig_fire -> exactly one 40-clk pulse, busy drops 60 clk after start.
//     A second fire while busy produces no pulse.
//  6. en dropped mid-high on ch0 -> trig_out=0 and busy=0 on the next clk.
//     With TRIG_PULSE_CNT_EN defined, 3 pulses -> trig_pulse_cnt[31:0]==3.

Source files
------------

// File: rtl/multi_trig_gen.sv
// Multi-channel trigger generator: a shared prescaler tick drives NCH periodic/one-shot pulse channels.
// Optional per-channel rising-edge counters are enabled with macro TRIG_PULSE_CNT_EN.
module multi_trig_gen #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 1_000,
    parameter int NCH         = 4,
    parameter int CNT_W       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         trig_en,
    input  logic [NCH-1:0]         trig_mode,
    input  logic [NCH-1:0]         trig_fire,
    input  logic [NCH*CNT_W-1:0]   trig_period,
    input  logic [NCH*CNT_W-1:0]   trig_width,
    input  logic [NCH*CNT_W-1:0]   trig_delay,
`ifdef TRIG_PULSE_CNT_EN
    output logic [NCH*32-1:0]      trig_pulse_cnt,
`endif
    output logic                   tick_out,
    output logic [NCH-1:0]         trig_out,
    output logic [NCH-1:0]         trig_busy
);

    localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2
    } state_e;

    logic [CW-1:0] pre_q;
    logic          tick;
    logic          tick_q;

    assign tick = (pre_q == CW'(DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= tick ? '0 : pre_q + CW'(1);
            tick_q <= tick;
        end
    end

    assign tick_out = tick_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] dc_q, dc_d, pc_q, pc_d;
        logic [CNT_W-1:0] per_q, per_d, wid_q, wid_d, dly_q, dly_d;
        logic             arm_q, arm_d;
        logic             out_q, out_d;
        logic             en, mode, fire;
        logic [CNT_W-1:0] period, width, delay;

        assign en     = trig_en[i];
        assign mode   = trig_mode[i];
        assign fire   = trig_fire[i];
        assign period = trig_period[i*CNT_W +: CNT_W];
        assign width  = trig_width[i*CNT_W +: CNT_W];
        assign delay  = trig_delay[i*CNT_W +: CNT_W];

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state_q <= IDLE;
                dc_q    <= '0;
                pc_q    <= '0;
                per_q   <= '0;
                wid_q   <= '0;
                dly_q   <= '0;
                arm_q   <= 1'b0;
                out_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                dc_q    <= dc_d;
                pc_q    <= pc_d;
                per_q   <= per_d;
                wid_q   <= wid_d;
                dly_q   <= dly_d;
                arm_q   <= arm_d;
                out_q   <= out_d;
            end
        end

        // Disable wins over everything; otherwise state only advances on a tick.
        always_comb begin
            state_d = state_q;
            dc_d    = dc_q;
            pc_d    = pc_q;
            per_d   = per_q;
            wid_d   = wid_q;
            dly_d   = dly_q;
            arm_d   = arm_q;
            if (!en) begin
                state_d = IDLE;
                arm_d   = 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (fire) begin
                            arm_d = 1'b1;
                        end
                        if (tick && (period != '0) && (!mode || arm_q)) begin
                            arm_d = 1'b0;
                            per_d = period;
                            wid_d = width;
                            dly_d = delay;
                            if (delay != '0) begin
                                state_d = DELAY;
                                dc_d    = '0;
                            end else begin
                                state_d = RUN;
                                pc_d    = '0;
                            end
                        end
                    end
                    DELAY: begin
                        if (tick) begin
                            if (dc_q == dly_q - CNT_W'(1)) begin
                                state_d = RUN;
                                pc_d    = '0;
                            end else begin
                                dc_d = dc_q + CNT_W'(1);
                            end
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            if (pc_q == per_q - CNT_W'(1)) begin
                                // A zero period at the wrap would latch P=0, so stop instead.
                                if (!mode && (period != '0)) begin
                                    per_d = period;
                                    wid_d = width;
                                    dly_d = delay;
                                    pc_d  = '0;
                                end else begin
                                    state_d = IDLE;
                                end
                            end else begin
                                pc_d = pc_q + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end

        always_comb begin
            out_d = (state_d == RUN) && (pc_d < wid_d);
        end

        assign trig_out[i]  = out_q;
        assign trig_busy[i] = (state_q != IDLE);

`ifdef TRIG_PULSE_CNT_EN
        logic [31:0] pcnt_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pcnt_q <= '0;
            end else if (out_d && !out_q) begin
                pcnt_q <= pcnt_q + 32'd1;
            end
        end

        assign trig_pulse_cnt[i*32 +: 32] = pcnt_q;
`endif
    end

endmodule
